rr_requester_agent: RTL

- Requester-side companion to the cyclic round-robin arbiter: accepts per-user job pulses, queues them, and drives the arbiter's one-hot-per-user request vector.
- Consumes the arbiter's grant vector, holds ownership for a fixed tenure, then releases so the arbiter can rotate.
- Also checks grant-protocol correctness and reports sticky errors.
- Sits between the job sources and the arbiter request/grant pins.

---
 rtl/rr_pkg.sv | 21 ++
 rtl/rr_user_agent.sv | 106 ++++++++++
 rtl/rr_requester_agent.sv | 82 ++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared types and defaults for the round-robin requester agent.
package rr_pkg;

    // Per-user ownership sequence seen from the requester side.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } user_state_e;

    localparam int NUM_USERS_DEF   = 3;
    localparam int CNT_W_DEF       = 4;
    localparam int HOLD_CYCLES_DEF = 2;

    // Width needed to hold values 0..HOLD_CYCLES in the tenure counter.
    function automatic int hold_cnt_w(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/rr_user_agent.sv
// One requester lane: job queue counter, ownership FSM and tenure timer.
//
// state | meaning
// IDLE  | no request; waits for a queued job
// REQ   | request raised, waiting for this user's grant bit
// OWN   | granted; tenure timer counts down to zero
// REL   | request dropped for one cycle so the arbiter can rotate
module rr_user_agent
    import rr_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_in,
    input  logic             granted,
    output logic             req,
    output logic             job_done,
    output logic [CNT_W-1:0] pending,
    output logic             overflow_evt,
    output logic             lost_grant_evt
);

    localparam int HW = hold_cnt_w(HOLD_CYCLES);
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    user_state_e      state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             dec;

    // Next-state, counter and event computation for this lane.
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        hold_d         = hold_q;
        done_d         = 1'b0;
        dec            = 1'b0;
        overflow_evt   = 1'b0;
        lost_grant_evt = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q != '0) state_d = REQ;
            end
            REQ: begin
                if (granted) begin
                    state_d = OWN;
                    dec     = 1'b1;
                    hold_d  = HOLD_LOAD;
                end
            end
            OWN: begin
                if (!granted) begin
                    lost_grant_evt = 1'b1;
                    state_d        = REL;
                end else if (hold_q == '0) begin
                    state_d = REL;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            REL: begin
                state_d = (pend_q != '0) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A simultaneous enqueue and dequeue cancel out and cannot overflow.
        if (job_in && !dec) begin
            if (pend_q == CNT_MAX) overflow_evt = 1'b1;
            else                   pend_d = pend_q + CNT_W'(1);
        end else if (dec && !job_in) begin
            pend_d = pend_q - CNT_W'(1);
        end

        req_d = (state_d == REQ) || (state_d == OWN);
    end

    // Lane state registers; request and done are registered from next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            hold_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    assign req      = req_q;
    assign job_done = done_q;
    assign pending  = pend_q;

endmodule

// File: rtl/rr_requester_agent.sv
// Requester-side companion to the round-robin arbiter: per-user lanes plus
// grant-protocol checking with sticky error reporting.
module rr_requester_agent
    import rr_pkg::*;
#(
    parameter int NUM_USERS   = NUM_USERS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_USERS-1:0]       job_in,
    input  logic [NUM_USERS-1:0]       granted,
    output logic [NUM_USERS-1:0]       user_requests,
    output logic [NUM_USERS-1:0]       job_done,
    output logic [NUM_USERS*CNT_W-1:0] pending_cnt,
    input  logic                       err_clr,
    output logic                       err_multi_grant,
    output logic                       err_grant_no_req,
    output logic                       err_lost_grant,
    output logic [NUM_USERS-1:0]       err_overflow
);

    logic [NUM_USERS-1:0] ovf_evt;
    logic [NUM_USERS-1:0] lost_evt;
    logic                 multi_evt;
    logic                 no_req_evt;

    logic                 err_multi_q, err_multi_d;
    logic                 err_no_req_q, err_no_req_d;
    logic                 err_lost_q, err_lost_d;
    logic [NUM_USERS-1:0] err_ovf_q, err_ovf_d;

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_user
        rr_user_agent #(
            .CNT_W       (CNT_W),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_agent (
            .clock          (clock),
            .reset          (reset),
            .job_in         (job_in[g]),
            .granted        (granted[g]),
            .req            (user_requests[g]),
            .job_done       (job_done[g]),
            .pending        (pending_cnt[g*CNT_W +: CNT_W]),
            .overflow_evt   (ovf_evt[g]),
            .lost_grant_evt (lost_evt[g])
        );
    end

    // Protocol checks against the registered request vector; a new error
    // detected in the same cycle as a clear still sets its bit.
    always_comb begin
        multi_evt    = ($countones(granted) > 1);
        no_req_evt   = |(granted & ~user_requests);
        err_multi_d  = (err_clr ? 1'b0 : err_multi_q)  | multi_evt;
        err_no_req_d = (err_clr ? 1'b0 : err_no_req_q) | no_req_evt;
        err_lost_d   = (err_clr ? 1'b0 : err_lost_q)   | (|lost_evt);
        err_ovf_d    = (err_clr ? '0   : err_ovf_q)    | ovf_evt;
    end

    // Sticky error registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_multi_q  <= 1'b0;
            err_no_req_q <= 1'b0;
            err_lost_q   <= 1'b0;
            err_ovf_q    <= '0;
        end else begin
            err_multi_q  <= err_multi_d;
            err_no_req_q <= err_no_req_d;
            err_lost_q   <= err_lost_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign err_multi_grant  = err_multi_q;
    assign err_grant_no_req = err_no_req_q;
    assign err_lost_grant   = err_lost_q;
    assign err_overflow     = err_ovf_q;

endmodule
